// File: rtl/ray_pkg.sv
// Shared types for the ray job dispatcher: dimensions, core limits, FSM states, job record.
// Latency/backpressure: not applicable (declarations only).
package ray_pkg;

    localparam int COORD_W_DEF = 13;
    localparam int MAX_CORES   = 4;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DONE
    } state_t;

    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic                   sof;
        logic                   eol;
        logic                   parity;
    } job_t;

    // Requests beyond the physically present cores fold onto the last real core index.
    function automatic logic [1:0] clamp_cores(input logic [1:0] req, input int num_cores);
        return (int'(req) >= num_cores) ? 2'(num_cores - 1) : req;
    endfunction

endpackage

// File: rtl/ray_job_dispatcher_if.sv
// Job offer bus from the dispatcher to the compute cores; one-hot valid, per-core ready.
// Latency/backpressure: wires only; a job is held until the targeted core raises ready.
interface ray_job_dispatcher_if #(
    parameter int NUM_CORES = 2,
    parameter int COORD_W   = 13
);
    logic [NUM_CORES-1:0] job_valid;
    logic [NUM_CORES-1:0] job_ready;
    logic [COORD_W-1:0]   job_x;
    logic [COORD_W-1:0]   job_y;
    logic                 job_sof;
    logic                 job_eol;
    logic                 job_parity;

    modport master (
        output job_valid, job_x, job_y, job_sof, job_eol, job_parity,
        input  job_ready
    );

    modport slave (
        input  job_valid, job_x, job_y, job_sof, job_eol, job_parity,
        output job_ready
    );
endinterface

// File: rtl/raster_counter.sv
// Raster-order x/y position with latched extents; last flags are combinational from registers.
// Latency: step/load take effect next cycle; backpressure: holds position while step is low.
module raster_counter #(
    parameter int COORD_W = 13
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last_in_line,
    output logic               last_in_frame
);
    logic [COORD_W-1:0] x_max_q;
    logic [COORD_W-1:0] y_max_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            x_max_q <= '0;
            y_max_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (load) begin
            // Zero extents wrap here, but the FSM never steps such a frame.
            x_max_q <= width - COORD_W'(1);
            y_max_q <= height - COORD_W'(1);
            x_q     <= '0;
            y_q     <= '0;
        end else if (step) begin
            if (last_in_line) begin
                x_q <= '0;
                y_q <= y_q + COORD_W'(1);
            end else begin
                x_q <= x_q + COORD_W'(1);
            end
        end
    end

    assign x             = x_q;
    assign y             = y_q;
    assign last_in_line  = (x_q == x_max_q);
    assign last_in_frame = last_in_line && (y_q == y_max_q);

endmodule

// File: rtl/ray_job_dispatcher.sv
// Frame scheduler: raster-order pixel jobs to active cores in strict round robin; job offered the cycle after start.
// Backpressure: job and target held until the addressed core is ready; other cores' ready ignored.
module ray_job_dispatcher
    import ray_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int COORD_W   = COORD_W_DEF
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic [COORD_W-1:0]   image_width,
    input  logic [COORD_W-1:0]   image_height,
    input  logic [1:0]           no_of_extra_cores,
    output logic                 busy,
    output logic                 frame_done,
    ray_job_dispatcher_if.master job
);
    state_t               state_q;
    state_t               state_d;
    logic [1:0]           ptr_q;
    logic [1:0]           last_core_q;
    logic                 parity_q;
    logic                 load;
    logic                 step;
    logic                 xfer;
    logic [NUM_CORES-1:0] offer;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic                 last_in_line;
    logic                 last_in_frame;

    raster_counter #(.COORD_W(COORD_W)) u_raster (
        .aclk          (aclk),
        .areset        (areset),
        .load          (load),
        .step          (step),
        .width         (image_width),
        .height        (image_height),
        .x             (x),
        .y             (y),
        .last_in_line  (last_in_line),
        .last_in_frame (last_in_frame)
    );

    always_comb begin
        offer = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            offer[k] = (state_q == DISPATCH) && (ptr_q == 2'(k));
        end
    end

    assign xfer = |(offer & job.job_ready);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (image_width == '0 || image_height == '0) ? DONE : DISPATCH;
                end
            end
            DISPATCH: begin
                step = xfer;
                if (xfer && last_in_frame) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            last_core_q <= '0;
            parity_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                ptr_q       <= '0;
                last_core_q <= clamp_cores(no_of_extra_cores, NUM_CORES);
            end else if (xfer) begin
                ptr_q <= (ptr_q == last_core_q) ? 2'd0 : ptr_q + 2'd1;
            end
            if (state_q == DONE) begin
                parity_q <= ~parity_q;
            end
        end
    end

    assign job.job_valid  = offer;
    assign job.job_x      = x;
    assign job.job_y      = y;
    assign job.job_sof    = (state_q == DISPATCH) && (x == '0) && (y == '0);
    assign job.job_eol    = (state_q == DISPATCH) && last_in_line;
    assign job.job_parity = parity_q;
    assign busy           = (state_q == DISPATCH);
    assign frame_done     = (state_q == DONE);

endmodule

// File: tb/tb_ray_job_dispatcher.sv
// Randomized bench for ray_job_dispatcher against a raster-order job list model.
module tb_ray_job_dispatcher;
    import ray_pkg::*;

    localparam int NC = 2;
    localparam int CW = 13;

    typedef struct {
        job_t j;
        int   core;
    } exp_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic          start;
    logic [CW-1:0] image_width;
    logic [CW-1:0] image_height;
    logic [1:0]    no_of_extra_cores;
    logic          busy;
    logic          frame_done;

    int total = 0;
    int bad   = 0;
    logic model_parity = 1'b0;

    ray_job_dispatcher_if #(.NUM_CORES(NC), .COORD_W(CW)) job_bus ();

    ray_job_dispatcher #(.NUM_CORES(NC), .COORD_W(CW)) dut (
        .aclk              (aclk),
        .areset            (areset),
        .start             (start),
        .image_width       (image_width),
        .image_height      (image_height),
        .no_of_extra_cores (no_of_extra_cores),
        .busy              (busy),
        .frame_done        (frame_done),
        .job               (job_bus.master)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(job_bus.job_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_parity"}, 32'(job_bus.job_parity), 32'(model_parity));
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
    endtask

    // mode 0: all ready; mode 1: random ready; mode 2: core 1 stalls 3 cycles first time targeted.
    task automatic run_frame(input int w, input int h, input int extra, input int mode, input int abort_at);
        exp_t       q[$];
        exp_t       e;
        int         nc;
        int         cyc;
        int         stall;
        logic [1:0] rdy;

        nc = (extra > NC - 1) ? NC - 1 : extra;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                e.j.x      = CW'(xx);
                e.j.y      = CW'(yy);
                e.j.sof    = (xx == 0 && yy == 0);
                e.j.eol    = (xx == w - 1);
                e.j.parity = model_parity;
                e.core     = (yy * w + xx) % (nc + 1);
                q.push_back(e);
            end
        end

        start             = 1'b1;
        image_width       = CW'(w);
        image_height      = CW'(h);
        no_of_extra_cores = 2'(extra);
        @(negedge aclk);
        start             = 1'b0;
        image_width       = CW'($urandom);
        image_height      = CW'($urandom);
        no_of_extra_cores = 2'($urandom);

        stall = 3;
        cyc   = 0;
        forever begin
            if (abort_at > 0 && cyc == abort_at) begin
                areset = 1'b1;
                start  = 1'b1;
                @(negedge aclk);
                model_parity = 1'b0;
                check_idle_outputs("abort");
                areset        = 1'b0;
                start         = 1'b0;
                job_bus.job_ready = '0;
                @(negedge aclk);
                check_idle_outputs("abort_start_ignored");
                return;
            end
            if (q.size() == 0) begin
                chk("done_pulse", 32'(frame_done), 32'd1);
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_valid", 32'(job_bus.job_valid), 32'd0);
                chk("done_parity", 32'(job_bus.job_parity), 32'(model_parity));
                model_parity = ~model_parity;
                start = 1'($urandom);
                @(negedge aclk);
                start = 1'b0;
                check_idle_outputs("after_done");
                return;
            end
            e = q[0];
            chk("valid", 32'(job_bus.job_valid), 32'(1) << e.core);
            chk("x", 32'(job_bus.job_x), 32'(e.j.x));
            chk("y", 32'(job_bus.job_y), 32'(e.j.y));
            chk("sof", 32'(job_bus.job_sof), 32'(e.j.sof));
            chk("eol", 32'(job_bus.job_eol), 32'(e.j.eol));
            chk("parity", 32'(job_bus.job_parity), 32'(e.j.parity));
            chk("busy", 32'(busy), 32'd1);
            chk("frame_done_early", 32'(frame_done), 32'd0);

            if (mode == 0) begin
                rdy = 2'b11;
            end else if (mode == 1) begin
                rdy = 2'($urandom);
            end else if (e.core == 1 && stall > 0) begin
                rdy = 2'b01;
                stall--;
            end else begin
                rdy = 2'b11;
            end
            job_bus.job_ready = rdy;
            start = ($urandom_range(7) == 0);
            if (rdy[e.core]) void'(q.pop_front());

            cyc++;
            if (cyc > 5000) begin
                chk("timeout", 32'd1, 32'd0);
                start = 1'b0;
                return;
            end
            @(negedge aclk);
        end
    endtask

    initial begin
        areset            = 1'b1;
        start             = 1'b0;
        image_width       = '0;
        image_height      = '0;
        no_of_extra_cores = '0;
        job_bus.job_ready = '0;
        repeat (3) @(negedge aclk);
        chk("rst_valid", 32'(job_bus.job_valid), 32'd0);
        chk("rst_x", 32'(job_bus.job_x), 32'd0);
        chk("rst_y", 32'(job_bus.job_y), 32'd0);
        chk("rst_sof", 32'(job_bus.job_sof), 32'd0);
        chk("rst_eol", 32'(job_bus.job_eol), 32'd0);
        chk("rst_parity", 32'(job_bus.job_parity), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        areset = 1'b0;
        @(negedge aclk);

        run_frame(4, 2, 1, 0, 0);
        run_frame(4, 2, 1, 2, 0);
        run_frame(3, 1, 0, 1, 0);
        run_frame(0, 5, 1, 1, 0);
        run_frame(3, 0, 1, 1, 0);
        run_frame(1, 1, 1, 1, 0);
        run_frame(16, 16, 1, 1, 40);
        run_frame(3, 2, 1, 0, 0);
        run_frame(5, 3, 3, 1, 0);
        run_frame(5, 3, 3, 1, 0);
        for (int i = 0; i < 6; i++) begin
            run_frame($urandom_range(1, 7), $urandom_range(1, 5), $urandom_range(0, 3), 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
